// File: rtl/lacc_rd_responder.sv
// lacc_rd_responder
// Memory-side responder for the line-accelerator read channel. Each accepted
// read command carries no address; its position in the BUF_W x BUF_D tile is
// implied by command order. Positions inside the configured image are fetched
// from a shared synchronous SRAM port. Positions outside it return zero
// without touching the SRAM. Responses keep command order and arrive at a
// fixed MEM_LAT+1 cycle latency, with no back-pressure.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a tile (IDLE only), latches cfg_*
//   cfg_base/stride     tile origin word address / words per image row
//   cfg_img_w/img_h     valid columns/rows; beyond these the word is padded
//   lacc_data_valid/ready   read command handshake
//   lacc_drsp_valid/rdata   response (single cycle, no ready)
//   mem_req/addr/gnt/rdata  SRAM read port
//   busy, done          activity flag, end-of-tile pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start, commands not accepted
// RUN   | accepting commands, one tile position per handshake
// DRAIN | all commands taken, waiting for the response pipeline to empty
module lacc_rd_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int BUF_W   = 16,
  parameter int BUF_D   = 8,
  parameter int MEM_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          cfg_base,
  input  logic [ADDR_W-1:0]          cfg_stride,
  input  logic [$clog2(BUF_W):0]     cfg_img_w,
  input  logic [$clog2(BUF_D):0]     cfg_img_h,
  input  logic                       lacc_data_valid,
  output logic                       lacc_data_ready,
  output logic                       lacc_drsp_valid,
  output logic [DATA_W-1:0]          lacc_drsp_rdata,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_gnt,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic                       done
);

  localparam int WW = $clog2(BUF_W) + 1;
  localparam int HW = $clog2(BUF_D) + 1;
  localparam int XW = (BUF_W > 1) ? $clog2(BUF_W) : 1;
  localparam int YW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int CW = (BUF_W * BUF_D > 1) ? $clog2(BUF_W * BUF_D) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic [CW-1:0]       cmd_cnt_q, cmd_cnt_d;
  logic [ADDR_W-1:0]   stride_q, stride_d;
  logic [WW-1:0]       img_w_q, img_w_d;
  logic [HW-1:0]       img_h_q, img_h_d;

  // {valid, pad} per pipeline stage; the tail lines up with mem_rdata.
  logic [MEM_LAT-1:0]  pipe_vld_q;
  logic [MEM_LAT-1:0]  pipe_pad_q;
  logic                rsp_vld_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic                pad;
  logic                hs;
  logic                pipe_empty;

  assign pad = (WW'(x_q) >= img_w_q) | (HW'(y_q) >= img_h_q);
  assign pipe_empty = ~(|pipe_vld_q) & ~rsp_vld_q;

  assign lacc_drsp_valid = rsp_vld_q;
  assign lacc_drsp_rdata = rsp_data_q;

  always_comb begin
    state_d         = state_q;
    x_d             = x_q;
    y_d             = y_q;
    row_addr_d      = row_addr_q;
    cmd_cnt_d       = cmd_cnt_q;
    stride_d        = stride_q;
    img_w_d         = img_w_q;
    img_h_d         = img_h_q;
    mem_req         = 1'b0;
    mem_addr        = '0;
    lacc_data_ready = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    hs              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          x_d        = '0;
          y_d        = '0;
          row_addr_d = cfg_base;
          cmd_cnt_d  = '0;
          stride_d   = cfg_stride;
          img_w_d    = cfg_img_w;
          img_h_d    = cfg_img_h;
        end
      end
      S_RUN: begin
        busy            = 1'b1;
        mem_req         = lacc_data_valid & ~pad;
        mem_addr        = row_addr_q + ADDR_W'(x_q);
        // Padded positions never wait on the arbiter.
        lacc_data_ready = pad | mem_gnt;
        hs              = lacc_data_valid & lacc_data_ready;
        if (hs) begin
          cmd_cnt_d = cmd_cnt_q + CW'(1);
          if (x_q == XW'(BUF_W - 1)) begin
            x_d        = '0;
            y_d        = y_q + YW'(1);
            row_addr_d = row_addr_q + stride_q;
          end else begin
            x_d = x_q + XW'(1);
          end
          if (cmd_cnt_q == CW'(BUF_W * BUF_D - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pipe_empty) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_addr_q <= '0;
      cmd_cnt_q  <= '0;
      stride_q   <= '0;
      img_w_q    <= '0;
      img_h_q    <= '0;
      pipe_vld_q <= '0;
      pipe_pad_q <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      row_addr_q    <= row_addr_d;
      cmd_cnt_q     <= cmd_cnt_d;
      stride_q      <= stride_d;
      img_w_q       <= img_w_d;
      img_h_q       <= img_h_d;
      pipe_vld_q[0] <= hs;
      pipe_pad_q[0] <= pad;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_pad_q[i] <= pipe_pad_q[i-1];
      end
      rsp_vld_q  <= pipe_vld_q[MEM_LAT-1];
      rsp_data_q <= (pipe_vld_q[MEM_LAT-1] && !pipe_pad_q[MEM_LAT-1]) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_lacc_rd_responder.sv
// Directed bench for lacc_rd_responder with a response scoreboard.
// Expected words and SRAM addresses for a tile are queued when the tile is
// started; the per-cycle monitor pops them as the DUT reads and responds.
module tb_lacc_rd_responder;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int BW  = 4;
  localparam int BD  = 3;
  localparam int LAT = 2;
  localparam int NCMD = BW * BD;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_stride;
  logic [2:0]    cfg_img_w;
  logic [2:0]    cfg_img_h;
  logic          lacc_data_valid;
  logic          lacc_data_ready;
  logic          lacc_drsp_valid;
  logic [DW-1:0] lacc_drsp_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;

  lacc_rd_responder #(
    .DATA_W(DW), .ADDR_W(AW), .BUF_W(BW), .BUF_D(BD), .MEM_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
    .lacc_data_valid(lacc_data_valid), .lacc_data_ready(lacc_data_ready),
    .lacc_drsp_valid(lacc_drsp_valid), .lacc_drsp_rdata(lacc_drsp_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word at addr is addr+0x100, returned LAT cycles later.
  logic [DW-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    rd_p0 <= {16'h0, mem_addr} + 32'h100;
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = rd_p1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_total = 0;
  int reads = 0;
  int last_hs_cyc = 0;
  int hs0, reads0, idx0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            lat_q[$];
  int            resp_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic sample();
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int t;
    if (lacc_data_valid && lacc_data_ready) begin
      hs_total++;
      last_hs_cyc = cyc;
      lat_q.push_back(cyc);
    end
    if (mem_req && mem_gnt) begin
      reads++;
      chk("read_expected", exp_addr_q.size() > 0, 1);
      if (exp_addr_q.size() > 0) begin
        a = exp_addr_q.pop_front();
        chk("mem_addr", mem_addr, a);
      end
    end
    if (lacc_drsp_valid) begin
      resp_cyc_q.push_back(cyc);
      chk("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        chk("rsp_data", lacc_drsp_rdata, d);
      end
      if (lat_q.size() > 0) begin
        t = lat_q.pop_front();
        chk("rsp_latency", cyc - t, LAT + 1);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_tile(input logic [AW-1:0] b, input logic [AW-1:0] s,
                            input int w, input int h);
    for (int i = 0; i < NCMD; i++) begin
      int x, y;
      logic p;
      logic [AW-1:0] a;
      x = i % BW;
      y = i / BW;
      p = (x >= w) || (y >= h);
      a = AW'(int'(b) + y * int'(s) + x);
      exp_q.push_back(p ? 32'h0 : ({16'h0, a} + 32'h100));
      if (!p) exp_addr_q.push_back(a);
    end
    hs0    = hs_total;
    reads0 = reads;
    idx0   = resp_cyc_q.size();
    cfg_base   = b;
    cfg_stride = s;
    cfg_img_w  = 3'(w);
    cfg_img_h  = 3'(h);
    start = 1'b1;
    chk("busy_before_start", busy, 0);
    tick();
    start = 1'b0;
    cfg_base   = 16'($urandom);
    cfg_stride = 16'($urandom);
    cfg_img_w  = 3'($urandom);
    cfg_img_h  = 3'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 100 && (hs_total - hs0) < n; i++) tick();
    chk("wait_hs", (hs_total - hs0) >= n, 1);
  endtask

  task automatic wait_done(input bit start_on_done);
    for (int i = 0; i < 100 && !done; i++) tick();
    chk("done_seen", done, 1);
    chk("done_latency", cyc - last_hs_cyc, LAT + 2);
    if (start_on_done) start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_done", busy, 0);
  endtask

  task automatic end_checks(input int exp_reads, input int exp_span);
    chk("rsp_left", exp_q.size(), 0);
    chk("reads_left", exp_addr_q.size(), 0);
    chk("read_count", reads - reads0, exp_reads);
    chk("hs_count", hs_total - hs0, NCMD);
    chk("rsp_count", resp_cyc_q.size() - idx0, NCMD);
    if (resp_cyc_q.size() > idx0)
      chk("rsp_span", resp_cyc_q[resp_cyc_q.size()-1] - resp_cyc_q[idx0], exp_span);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, lacc_data_ready, 0);
    chk({tag, "_drsp_valid"}, lacc_drsp_valid, 0);
    chk({tag, "_drsp_rdata"}, lacc_drsp_rdata, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int r0;
    rst = 1'b1;
    start = 1'b0;
    cfg_base = '0;
    cfg_stride = '0;
    cfg_img_w = '0;
    cfg_img_h = '0;
    lacc_data_valid = 1'b0;
    mem_gnt = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Commands offered while IDLE are not taken.
    lacc_data_valid = 1'b1;
    #1;
    chk("idle_ready", lacc_data_ready, 0);
    chk("idle_mem_req", mem_req, 0);
    tick();
    lacc_data_valid = 1'b0;
    tick();

    // Full image, valid held through DRAIN.
    start_tile(16'h0010, 16'd8, 4, 3);
    lacc_data_valid = 1'b1;
    wait_done(1'b0);
    lacc_data_valid = 1'b0;
    end_checks(12, NCMD - 1);

    // Padding, with a start pulse in the done cycle that must be ignored.
    start_tile(16'h0010, 16'd8, 2, 2);
    lacc_data_valid = 1'b1;
    wait_done(1'b1);
    lacc_data_valid = 1'b0;
    repeat (4) tick();
    chk("busy_after_done_start", busy, 0);
    end_checks(4, NCMD - 1);

    // Grant stall at command 5.
    start_tile(16'h0010, 16'd8, 4, 3);
    lacc_data_valid = 1'b1;
    wait_hs(5);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", lacc_data_ready, 0);
      chk("stall_mem_req", mem_req, 1);
      chk("stall_mem_addr", mem_addr, 16'h0019);
      tick();
    end
    mem_gnt = 1'b1;
    wait_done(1'b0);
    lacc_data_valid = 1'b0;
    end_checks(12, NCMD - 1 + 3);

    // Address wrap modulo 2^16.
    start_tile(16'hFFFE, 16'd2, 4, 3);
    lacc_data_valid = 1'b1;
    wait_done(1'b0);
    lacc_data_valid = 1'b0;
    end_checks(12, NCMD - 1);

    // start during RUN and during DRAIN is ignored.
    start_tile(16'h0010, 16'd8, 4, 3);
    lacc_data_valid = 1'b1;
    wait_hs(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_hs(NCMD);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0);
    lacc_data_valid = 1'b0;
    repeat (5) tick();
    chk("busy_after_ctrl", busy, 0);
    end_checks(12, NCMD - 1);

    // Reset after five handshakes.
    start_tile(16'h0010, 16'd8, 4, 3);
    lacc_data_valid = 1'b1;
    wait_hs(5);
    lacc_data_valid = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_addr_q.delete();
    lat_q.delete();
    chk_all_zero("midrst");
    rst = 1'b0;
    r0 = resp_cyc_q.size();
    repeat (8) tick();
    chk("rsp_after_rst", resp_cyc_q.size() - r0, 0);
    chk("busy_after_rst", busy, 0);

    // Clean tile after reset.
    start_tile(16'h0010, 16'd8, 4, 3);
    lacc_data_valid = 1'b1;
    wait_done(1'b0);
    lacc_data_valid = 1'b0;
    end_checks(12, NCMD - 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
